// File: rtl/mm_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : mm_operand_loader
// Description : Serial-to-parallel operand stage for the 3x3-by-3x1 matrix
//               multiplier. Collects twelve signed elements (A row-major,
//               then B) from a valid/ready stream and holds them as
//               registered parallel operands under an op_valid/op_ready
//               handshake.
// Option      : MM_LOADER_SOF_EN adds in_sof (frame restart) and frame_err.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef FACTOR_WIDTH_DEFAULT
`define FACTOR_WIDTH_DEFAULT 8
`endif

module mm_operand_loader #(
  parameter int NBITS = `FACTOR_WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [NBITS-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [NBITS-1:0] A_11,
  output logic signed [NBITS-1:0] A_12,
  output logic signed [NBITS-1:0] A_13,
  output logic signed [NBITS-1:0] A_21,
  output logic signed [NBITS-1:0] A_22,
  output logic signed [NBITS-1:0] A_23,
  output logic signed [NBITS-1:0] A_31,
  output logic signed [NBITS-1:0] A_32,
  output logic signed [NBITS-1:0] A_33,
  output logic signed [NBITS-1:0] B_11,
  output logic signed [NBITS-1:0] B_21,
  output logic signed [NBITS-1:0] B_31,
  output logic                    op_valid,
  input  logic                    op_ready
`ifdef MM_LOADER_SOF_EN
  ,
  input  logic                    in_sof,
  output logic                    frame_err
`endif
);

  localparam logic [0:0] c_LOAD     = 1'b0;
  localparam logic [0:0] c_FULL     = 1'b1;
  localparam logic [3:0] c_LAST_IDX = 4'd11;
  localparam int         c_NUM_ELEM = 12;

  logic [0:0]              r_state;
  logic [3:0]              r_idx;
  logic signed [NBITS-1:0] r_op [0:c_NUM_ELEM-1];

  logic       w_accept;
  logic [3:0] w_wr_idx;
  logic [3:0] w_next_idx;
  logic       w_last;

  assign w_accept = in_valid && (r_state == c_LOAD);

  // Resolve which operand slot this accept targets and where idx goes next
  always_comb begin
    w_wr_idx = r_idx;
`ifdef MM_LOADER_SOF_EN
    // A start-of-frame word always lands in A_11, restarting the frame
    if (in_sof) begin
      w_wr_idx = 4'd0;
    end
`endif
    w_next_idx = (w_wr_idx == c_LAST_IDX) ? 4'd0 : (w_wr_idx + 4'd1);
    w_last     = w_accept && (w_wr_idx == c_LAST_IDX);
  end

  // Frame state and element index; FULL is left only when downstream consumes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_LOAD;
      r_idx   <= 4'd0;
    end else if (r_state == c_LOAD) begin
      if (w_accept) begin
        r_idx <= w_next_idx;
      end
      if (w_last) begin
        r_state <= c_FULL;
      end
    end else begin
      if (op_ready) begin
        r_state <= c_LOAD;
      end
    end
  end

  // Operand registers: only the addressed slot is written on an accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < c_NUM_ELEM; k++) begin
        r_op[k] <= '0;
      end
    end else if (w_accept) begin
      for (int k = 0; k < c_NUM_ELEM; k++) begin
        if (w_wr_idx == 4'(k)) begin
          r_op[k] <= in_data;
        end
      end
    end
  end

`ifdef MM_LOADER_SOF_EN
  logic r_frame_err;

  // One-cycle pulse when a start-of-frame word abandons a partial frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_accept && in_sof && (r_idx != 4'd0);
    end
  end

  assign frame_err = r_frame_err;
`endif

  // Handshake outputs come straight from the state register
  assign in_ready = (r_state == c_LOAD);
  assign op_valid = (r_state == c_FULL);

  assign A_11 = r_op[0];
  assign A_12 = r_op[1];
  assign A_13 = r_op[2];
  assign A_21 = r_op[3];
  assign A_22 = r_op[4];
  assign A_23 = r_op[5];
  assign A_31 = r_op[6];
  assign A_32 = r_op[7];
  assign A_33 = r_op[8];
  assign B_11 = r_op[9];
  assign B_21 = r_op[10];
  assign B_31 = r_op[11];

endmodule

`default_nettype wire

// File: tb/tb_mm_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mm_operand_loader
// Description : Scoreboard bench for mm_operand_loader. The driver keeps a
//               frame-level model (word count, collected frame, full flag)
//               and queues each completed frame; a monitor compares the DUT
//               outputs one cycle-step after every rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mm_operand_loader;

  localparam int NB = 8;
  typedef logic [11:0][NB-1:0] frame_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [NB-1:0] in_data = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [NB-1:0] A_11, A_12, A_13, A_21, A_22, A_23, A_31, A_32, A_33;
  logic signed [NB-1:0] B_11, B_21, B_31;
  logic                 op_valid;
  logic                 op_ready = 1'b0;
`ifdef MM_LOADER_SOF_EN
  logic                 in_sof = 1'b0;
  logic                 frame_err;
`endif

  mm_operand_loader #(.NBITS(NB)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .A_11(A_11), .A_12(A_12), .A_13(A_13),
    .A_21(A_21), .A_22(A_22), .A_23(A_23),
    .A_31(A_31), .A_32(A_32), .A_33(A_33),
    .B_11(B_11), .B_21(B_21), .B_31(B_31),
    .op_valid(op_valid), .op_ready(op_ready)
`ifdef MM_LOADER_SOF_EN
    , .in_sof(in_sof), .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  frame_t got;
  assign got = {B_31, B_21, B_11, A_33, A_32, A_31, A_23, A_22, A_21, A_13, A_12, A_11};

  int     checks = 0;
  int     errors = 0;
  // Reference model: words collected so far, frame being built, queue of
  // completed frames, and the expected post-edge full/err flags.
  int     cnt = 0;
  frame_t cur = '0;
  frame_t q[$];
  bit     exp_full = 1'b0;
  bit     exp_err = 1'b0;
  bit     alt = 1'b0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; model state is advanced to its post-edge value
  task automatic step(input bit v, input logic [NB-1:0] d, input bit ordy, input bit sof,
                      output bit acc);
    bit full_n;
    bit err_n;
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    op_ready = ordy;
`ifdef MM_LOADER_SOF_EN
    in_sof   = sof;
`endif
    acc    = v && !exp_full;
    full_n = exp_full;
    err_n  = 1'b0;
    if (exp_full && ordy) full_n = 1'b0;
    if (acc) begin
`ifdef MM_LOADER_SOF_EN
      if (sof) begin
        if (cnt != 0) err_n = 1'b1;
        cnt = 0;
      end
`endif
      cur[cnt] = d;
      cnt++;
      if (cnt == 12) begin
        q.push_back(cur);
        cnt    = 0;
        full_n = 1'b1;
      end
    end
    exp_full = full_n;
    exp_err  = err_n;
  endtask

  // Offer one word until the model says it was accepted.
  // bub: 0 = always valid, 1 = alternate, 2 = random; rdy: 0/1 fixed, 2 random
  task automatic send(input logic [NB-1:0] d, input int bub, input int rdy, input bit sof);
    bit acc;
    bit v;
    bit r;
    int tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 200) begin
      case (bub)
        0:       v = 1'b1;
        1:       begin v = alt; alt = !alt; end
        default: v = ($urandom_range(3) != 0);
      endcase
      r = (rdy == 2) ? 1'($urandom_range(1)) : (rdy != 0);
      step(v, d, r, sof, acc);
      tries++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=not_accepted required=accepted at %0t", $time);
    end
  endtask

  task automatic idle(input int n, input bit v, input logic [NB-1:0] d, input bit ordy);
    bit acc;
    repeat (n) step(v, d, ordy, 1'b0, acc);
  endtask

  // Asynchronous reset pulsed between edges; outputs must clear at once
  task automatic reset_mid;
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    cnt      = 0;
    exp_full = 1'b0;
    exp_err  = 1'b0;
    #2;
    check("rst_op_valid", 96'(op_valid), 96'd0);
    check("rst_in_ready", 96'(in_ready), 96'd1);
    check("rst_operands", 96'(got), 96'd0);
`ifdef MM_LOADER_SOF_EN
    check("rst_frame_err", 96'(frame_err), 96'd0);
`endif
    #1 rst = 1'b0;
  endtask

  // Monitor: handshake flags every cycle, frame compare on op_valid
  initial begin : monitor
    bit     prev;
    frame_t held;
    prev = 1'b0;
    held = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        check("op_valid", 96'(op_valid), 96'(exp_full));
        check("in_ready", 96'(in_ready), 96'(!exp_full));
`ifdef MM_LOADER_SOF_EN
        check("frame_err", 96'(frame_err), 96'(exp_err));
`endif
        if (op_valid) begin
          if (!prev) begin
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_frame actual=op_valid required=no_frame at %0t", $time);
            end else begin
              held = q.pop_front();
            end
          end
          check("frame", 96'(got), 96'(held));
        end
        prev = op_valid;
      end
    end
  end

  initial begin : main
    logic [NB-1:0] sv [4];
    sv[0] = 8'h80; sv[1] = 8'h7f; sv[2] = 8'hff; sv[3] = 8'h00;

    // Reset state
    @(negedge clk);
    check("init_op_valid", 96'(op_valid), 96'd0);
    check("init_in_ready", 96'(in_ready), 96'd1);
    check("init_operands", 96'(got), 96'd0);
    rst = 1'b0;

    // Frame 1..12, held with op_ready low while 0x55 is offered
    for (int i = 1; i <= 12; i++) send(NB'(i), 0, 0, 1'b0);
    idle(5, 1'b1, 8'h55, 1'b0);

    // Consume, then frame 13..24 back-to-back
    for (int i = 13; i <= 24; i++) send(NB'(i), 0, 1, 1'b0);

    // Sign extremes with a bubble every other cycle
    for (int i = 0; i < 12; i++) send((i < 4) ? sv[i] : NB'(i * 37 - 100), 1, 1, 1'b0);

    // Reset after five accepts, then a clean frame
    idle(3, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) send(NB'($urandom), 0, 1, 1'b0);
    reset_mid();
    for (int i = 0; i < 12; i++) send(NB'($urandom), 2, 2, 1'b0);

    // Random traffic
    for (int f = 0; f < 20; f++)
      for (int i = 0; i < 12; i++) send(NB'($urandom), 2, 2, 1'b0);

`ifdef MM_LOADER_SOF_EN
    // Restart on the 7th word, then a frame with sof at idx 0
    idle(3, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) send(NB'(100 + i), 0, 1, 1'b0);
    send(NB'(42), 0, 1, 1'b1);
    for (int i = 0; i < 11; i++) send(NB'(50 + i), 0, 1, 1'b0);
    send(NB'(7), 2, 1, 1'b1);
    for (int i = 0; i < 11; i++) send(NB'($urandom), 2, 2, 1'b0);
`endif

    // Drain and make sure every queued frame was presented
    idle(4, 1'b0, 8'h00, 1'b1);
    check("frames_pending", 96'(q.size()), 96'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
